// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier.
//   N      : operand width, fixed by the 4-bit add_sub datapath
//   ITER   : Booth iterations per multiply (one per operand bit)
//   CNT_W  : width of the iteration counter
//   state_t: controller state encoding
package booth_pkg;
  localparam int N     = 4;
  localparam int ITER  = N;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/booth_mult_4bit_add_sub.sv
// 4-bit ripple add/subtract stage built from full-adder cells.
//   a, b : operands
//   c    : 0 = a+b, 1 = a-b (b inverted, c used as carry-in)
//   s    : 4-bit sum/difference
//   co   : carry out of the top cell
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_sub import booth_pkg::*; (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c,
  output logic [N-1:0] s,
  output logic         co
);
  logic [N:0] cy;
  assign cy[0] = c;

  for (genvar i = 0; i < N; i++) begin : g_fa
    fa u_fa (
      .a  (a[i]),
      .b  (b[i] ^ c),
      .ci (cy[i]),
      .s  (s[i]),
      .co (cy[i+1])
    );
  end

  assign co = cy[N];
endmodule

// File: rtl/booth_mult_4bit.sv
// Sequential radix-2 Booth multiplier, signed 4b x 4b -> signed 8b.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (m multiplicand, q multiplier)
//   out_valid/out_ready : product handshake
//   product             : registered signed product, valid while out_valid
// One Booth step (add/sub + arithmetic right shift) per CALC cycle.
module booth_mult_4bit import booth_pkg::*; (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   m,
  input  logic [N-1:0]   q,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product
);
  state_t           state;
  logic [N-1:0]     acc, qr, mcand;
  logic             q_m1;
  logic [CNT_W-1:0] cnt;

  logic [N-1:0] sum, b_eff, r, acc_nxt, qr_nxt;
  logic         co, sub, do_op, ovf, sgn;

  // Pair {qr[0],q_m1}: 10 -> subtract, 01 -> add, 00/11 -> pass acc.
  assign sub   = qr[0] & ~q_m1;
  assign do_op = qr[0] ^ q_m1;
  assign b_eff = mcand ^ {N{sub}};

  add_sub u_add_sub (
    .a  (acc),
    .b  (mcand),
    .c  (sub),
    .s  (sum),
    .co (co)
  );

  // The shift must carry the true sign of the N+1-bit result; when the
  // N-bit add/sub overflows (e.g. 0 - (-8)) sum[N-1] is the wrong sign.
  assign ovf     = do_op & (acc[N-1] == b_eff[N-1]) & (sum[N-1] != acc[N-1]);
  assign r       = do_op ? sum : acc;
  assign sgn     = r[N-1] ^ ovf;
  assign acc_nxt = {sgn, r[N-1:1]};
  assign qr_nxt  = {r[0], qr[N-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      qr        <= '0;
      q_m1      <= 1'b0;
      mcand     <= '0;
      cnt       <= '0;
      product   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mcand    <= m;
          qr       <= q;
          acc      <= '0;
          q_m1     <= 1'b0;
          cnt      <= '0;
          in_ready <= 1'b0;
          state    <= CALC;
        end
        CALC: begin
          acc  <= acc_nxt;
          qr   <= qr_nxt;
          q_m1 <= qr[0];
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITER - 1)) begin
            product   <= {acc_nxt, qr_nxt};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Carry out is not part of the datapath; it only cross-checks the adder.
  assert property (@(posedge clk) disable iff (rst)
    (state == CALC) |-> ({co, sum} == (5'(acc) + 5'(b_eff) + 5'(sub))));
endmodule

// File: tb/tb_booth_mult_4bit.sv
// Directed + exhaustive check of booth_mult_4bit.
module tb_booth_mult_4bit;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [3:0] m, q;
  logic       out_valid, out_ready;
  logic [7:0] product;

  int nvec = 0;
  int nerr = 0;

  booth_mult_4bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .m         (m),
    .q         (q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present operands and complete the accepting edge.
  task automatic issue(input logic [3:0] mi, input logic [3:0] qi);
    int g = 0;
    m = mi; q = qi; in_valid = 1'b1;
    while (!in_ready && g < 20) begin tick(); g++; end
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges after the accepting edge until out_valid is seen.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin tick(); cyc++; end
  endtask

  task automatic directed(input string tag, input logic [3:0] mi, input logic [3:0] qi,
                          input logic [7:0] exp);
    int cyc;
    out_ready = 1'b1;
    issue(mi, qi);
    wait_valid(cyc);
    chk({tag, "_lat"}, cyc, 4);
    chk({tag, "_prod"}, product, exp);
    tick();
    chk({tag, "_rdy_after"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int cyc, hs;
    logic [7:0] exp8;
    rst = 1'b1; in_valid = 1'b0; m = '0; q = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_prod", product, 8'h00);
    chk("reset_hs", {out_valid, in_ready}, 2'b01);

    directed("3x5",   4'd3,    4'd5,    8'b0000_1111);
    directed("m8xm8", 4'b1000, 4'b1000, 8'b0100_0000);
    directed("m8x7",  4'b1000, 4'd7,    8'b1100_1000);
    directed("0xm1",  4'd0,    4'b1111, 8'h00);

    // Backpressure, with junk operands offered during CALC/DONE.
    out_ready = 1'b0;
    issue(4'd2, 4'b1101);
    m = 4'd7; q = 4'd7; in_valid = 1'b1;
    wait_valid(cyc);
    chk("bp_lat", cyc, 4);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_prod", product, 8'b1111_1010);
      chk("bp_hold_hs", {out_valid, in_ready}, 2'b10);
      tick();
    end
    chk("bp_hold_prod", product, 8'b1111_1010);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release", {out_valid, in_ready}, 2'b01);

    // Reset during the second CALC iteration.
    issue(4'd3, 4'd5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_prod", product, 8'h00);
    chk("rst_mid_hs", {out_valid, in_ready}, 2'b01);
    hs = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) hs++;
      tick();
    end
    chk("rst_mid_no_out", hs, 0);
    directed("1x1", 4'd1, 4'd1, 8'h01);

    // Exhaustive sweep with random backpressure.
    hs = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [3:0] ma, qb;
        logic       got;
        ma = 4'(a); qb = 4'(b);
        exp8 = 8'($signed(ma) * $signed(qb));
        out_ready = 1'b0;
        issue(ma, qb);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 60) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            chk("sweep_prod", product, exp8);
            got = 1'b1;
            hs++;
          end
          tick();
          cyc++;
        end
        chk("sweep_single", {got, out_valid, in_ready}, 3'b101);
      end
    end
    chk("sweep_count", hs, 256);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
